instr_prefetch_queue: RTL and testbench

- Sits directly upstream of the core's fetch stage, between the core's instruction port and a valid/ready instruction memory bus.
- Issues sequential word fetches ahead of demand and buffers the returned instructions, each tagged with its PC, in an in-order FIFO.
- On a redirect (a taken jump or branch), it flushes the FIFO and discards any responses still in flight.

---
 rtl/instr_prefetch_queue.sv | 112 +++++++++++
 tb/tb_instr_prefetch_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: runs sequential word fetches ahead of the fetch stage
// and buffers {pc, instr} pairs in order; a redirect flushes and discards in-flight data.
module instr_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [31:0]     fifo_instr [DEPTH];
    logic [XLEN-1:0] req_pc     [DEPTH];
    logic [AW:0]     rd_ptr;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     fifo_count;
    logic [AW:0]     outstanding;
    logic [AW:0]     discard;
    logic [AW-1:0]   req_rd;
    logic [AW-1:0]   req_wr;
    logic [AW+1:0]   credit_used;
    logic            req_fire;
    logic            rsp_ok;
    logic            push;
    logic            pop;
    logic            unused_addr_bits;

    // Buffered entries plus in-flight requests (including discards) share one credit pool,
    // so a returning response always finds room in the FIFO.
    assign fifo_count    = wr_ptr - rd_ptr;
    assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign mem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_C);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding is a bus violation and is ignored entirely.
    assign rsp_ok = mem_rsp_valid && (outstanding != '0);
    assign push   = rsp_ok && (discard == '0) && !redirect_valid;

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = fifo_instr[rd_ptr[AW-1:0]];
    assign out_pc    = fifo_pc[rd_ptr[AW-1:0]];

    assign unused_addr_bits = &{1'b0, redirect_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= '0;
            discard     <= '0;
            req_rd      <= '0;
            req_wr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
                req_pc[i]     <= '0;
            end
        end else begin
            if (req_fire) begin
                req_pc[req_wr] <= fetch_pc;
                req_wr         <= req_wr + AW'(1);
            end
            if (rsp_ok) begin
                req_rd <= req_rd + AW'(1);
            end
            outstanding <= outstanding + (AW+1)'(req_fire) - (AW+1)'(rsp_ok);

            if (redirect_valid) begin
                // Every request still in flight after this cycle's response becomes a discard.
                fetch_pc <= {redirect_addr[XLEN-1:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= outstanding - (AW+1)'(rsp_ok);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    fifo_pc[wr_ptr[AW-1:0]]    <= req_pc[req_rd];
                    fifo_instr[wr_ptr[AW-1:0]] <= mem_rsp_data;
                    wr_ptr                     <= wr_ptr + (AW+1)'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
                if (rsp_ok && (discard != '0)) begin
                    discard <= discard - (AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: randomized bus/consumer behaviour, a sequential-PC
// reference model feeding an expected queue, and a decoupled output monitor.
module tb_instr_prefetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;

    instr_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endfunction

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_9617;
    endfunction

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int due; } bus_t;
    exp_t exp_q[$];
    bus_t bus_q[$];

    // Knobs owned by the main sequence
    int          ready_pct = 100;
    int          acc_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          drv_en = 1'b0;
    int          redir_seq = 0;
    logic [31:0] redir_target = '0;
    int          stale_seq = 0;

    // State owned by the driver
    int cyc = 0;
    int redir_done = 0;

    // State owned by the reference model
    logic [31:0] model_pc = RESET_PC;
    bit          nxt_rsp_valid = 1'b0;
    logic [31:0] nxt_rsp_data = '0;
    int          stale_done = 0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    int          lat;
    exp_t        e_new;
    bus_t        b_new;
    exp_t        e_mon;

    // Driver: applies this cycle's inputs shortly after the rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!drv_en) begin
            out_ready      = 1'b0;
            mem_req_ready  = 1'b0;
            redirect_valid = 1'b0;
            redirect_addr  = '0;
            mem_rsp_valid  = 1'b0;
            mem_rsp_data   = '0;
        end else begin
            out_ready      = (int'($urandom_range(99)) < ready_pct);
            mem_req_ready  = (int'($urandom_range(99)) < acc_pct);
            redirect_valid = (redir_seq != redir_done);
            redirect_addr  = redirect_valid ? redir_target : $urandom;
            redir_done     = redir_seq;
            mem_rsp_valid  = nxt_rsp_valid;
            mem_rsp_data   = nxt_rsp_data;
        end
    end

    // Reference model: the output stream is the sequential PCs from the last restart point;
    // every accepted request adds one expected entry, every redirect or reset drops them all.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            exp_q.delete();
            bus_q.delete();
            model_pc      = RESET_PC;
            prev_pend     = 1'b0;
            nxt_rsp_valid = 1'b0;
        end else begin
            if (redirect_valid) begin
                check("no_req_in_redirect", mem_req_valid, 0);
                if (mem_req_valid && mem_req_ready) begin
                    b_new.addr = mem_req_addr;
                    b_new.due  = cyc + 1;
                    bus_q.push_back(b_new);
                end
                exp_q.delete();
                model_pc  = {redirect_addr[31:2], 2'b00};
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    check("req_hold_valid", mem_req_valid, 1);
                    check("req_hold_addr", mem_req_addr, prev_addr);
                end
                if (mem_req_valid && mem_req_ready) begin
                    check("req_addr", mem_req_addr, model_pc);
                    e_new.pc    = model_pc;
                    e_new.instr = mem_word(model_pc);
                    exp_q.push_back(e_new);
                    check("credit_bound", (exp_q.size() <= DEPTH), 1);
                    lat        = lat_min + int'($urandom_range(lat_max - lat_min));
                    b_new.addr = mem_req_addr;
                    b_new.due  = cyc + lat;
                    bus_q.push_back(b_new);
                    model_pc   = model_pc + 32'd4;
                end
                prev_pend = mem_req_valid && !mem_req_ready;
                prev_addr = mem_req_addr;
            end
            nxt_rsp_valid = 1'b0;
            nxt_rsp_data  = $urandom;
            if (stale_seq != stale_done) begin
                stale_done    = stale_seq;
                nxt_rsp_valid = 1'b1;
                nxt_rsp_data  = 32'hDEAD_BEEF;
            end else if (bus_q.size() > 0 && bus_q[0].due <= cyc + 1) begin
                nxt_rsp_valid = 1'b1;
                nxt_rsp_data  = mem_word(bus_q[0].addr);
                void'(bus_q.pop_front());
            end
        end
    end

    // Monitor: every output handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_when_empty", out_valid, 0);
            end else begin
                e_mon = exp_q.pop_front();
                check("out_pc", out_pc, e_mon.pc);
                check("out_instr", out_instr, e_mon.instr);
            end
        end
    end

    task automatic do_redirect(input logic [31:0] t);
        redir_target = t;
        redir_seq++;
        @(negedge clk);
    endtask

    task automatic wait_accept(input string name, output logic [31:0] addr);
        bit found = 1'b0;
        addr = '0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                found = 1'b1;
                addr  = mem_req_addr;
            end
        end
        if (!found) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_out(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = out_valid;
        end
        if (!found) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int n_out;
        int n_acc;

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);

        // Zero-wait bus, consumer always ready
        rst_n  = 1'b1;
        drv_en = 1'b1;
        wait_accept("t1_first_req", a);
        check("t1_first_req_addr", a, RESET_PC);
        @(negedge clk);
        check("t1_out_not_yet", out_valid, 0);
        @(negedge clk);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_pc", out_pc, RESET_PC);
        n_out = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid && out_ready) n_out++;
        end
        check("t1_throughput", n_out, 20);

        // Consumer stalled: credits cap in-flight plus buffered entries at DEPTH
        ready_pct = 0;
        do_redirect(32'h0000_3000);
        n_acc = 0;
        repeat (12) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) n_acc++;
        end
        check("t2_accept_count", n_acc, DEPTH);
        check("t2_req_stalled", mem_req_valid, 0);
        check("t2_full_valid", out_valid, 1);
        check("t2_head_pc", out_pc, 32'h0000_3000);
        ready_pct = 100;
        n_out = 0;
        n_acc = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid && out_ready) n_out++;
            if (mem_req_valid && mem_req_ready) n_acc++;
        end
        check("t2_drain", n_out, 8);
        check("t2_resume", (n_acc > 0), 1);

        // Slow bus: in-flight responses must be discarded after a redirect
        lat_min = 3;
        lat_max = 3;
        repeat (10) @(negedge clk);
        do_redirect(32'h0000_2002);
        check("t3_no_req", mem_req_valid, 0);
        wait_accept("t3_req", a);
        check("t3_req_addr", a, 32'h0000_2000);
        wait_out("t3_out");
        check("t3_out_pc", out_pc, 32'h0000_2000);

        // Redirect coinciding with a response and an output handshake
        lat_min = 1;
        lat_max = 1;
        repeat (10) @(negedge clk);
        do_redirect(32'h0000_4000);
        check("t4_rsp_present", mem_rsp_valid, 1);
        check("t4_handshake", (out_valid && out_ready), 1);
        check("t4_no_req", mem_req_valid, 0);
        @(negedge clk);
        check("t4_flushed", out_valid, 0);
        @(negedge clk);
        check("t4_still_empty", out_valid, 0);
        @(negedge clk);
        check("t4_refill", out_valid, 1);
        check("t4_refill_pc", out_pc, 32'h0000_4000);

        // Address wrap at the top of the address space
        do_redirect(32'hFFFF_FFF8);
        wait_accept("t5_req0", a);
        check("t5_addr0", a, 32'hFFFF_FFF8);
        wait_accept("t5_req1", a);
        check("t5_addr1", a, 32'hFFFF_FFFC);
        wait_accept("t5_req2", a);
        check("t5_addr2", a, 32'h0000_0000);

        // Randomized traffic with random redirects
        for (int k = 0; k < 2000; k++) begin
            if (k % 250 == 0) begin
                ready_pct = 30 + int'($urandom_range(70));
                acc_pct   = 40 + int'($urandom_range(60));
                lat_min   = 1;
                lat_max   = 1 + int'($urandom_range(3));
            end
            @(negedge clk);
            if ($urandom_range(24) == 0) begin
                case ($urandom_range(2))
                    0: redir_target = $urandom;
                    1: redir_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                    default: redir_target = $urandom & 32'h0000_FFFC;
                endcase
                redir_seq++;
            end
        end

        // Reset asserted mid-stream with the FIFO full
        ready_pct = 0;
        acc_pct   = 100;
        lat_min   = 1;
        lat_max   = 1;
        repeat (12) @(negedge clk);
        check("t7_full_valid", out_valid, 1);
        check("t7_full_no_req", mem_req_valid, 0);
        #3;
        rst_n  = 1'b0;
        drv_en = 1'b0;
        #1;
        check("t7_async_out_valid", out_valid, 0);
        check("t7_async_req_valid", mem_req_valid, 0);
        check("t7_async_out_pc", out_pc, 0);
        repeat (2) @(negedge clk);
        stale_seq++;
        ready_pct = 100;
        rst_n     = 1'b1;
        drv_en    = 1'b1;
        wait_accept("t7_req", a);
        check("t7_req_addr", a, RESET_PC);
        wait_out("t7_out");
        check("t7_out_pc", out_pc, RESET_PC);
        check("t7_out_instr", out_instr, mem_word(RESET_PC));
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
